// File: rtl/packetizer_param.sv
// packetizer_param: wraps one SRAM read stream into a head/body/tail
// flit packet for the router input FIFO, with backpressure and sequence tag.
module packetizer_param #(
    parameter int FLIT_W   = 256,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 4,
    parameter int MAX_BODY = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  body_len,
    input  logic [DATA_W-1:0] sram_data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              fifo_full,
    output logic [FLIT_W-1:0] flit_out,
    output logic              write_enable,
    output logic              busy,
    output logic              pkt_done
);

    localparam int REP = FLIT_W / DATA_W;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BODY);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_TAIL = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dest;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [7:0]        r_seq;
    logic [FLIT_W-1:0] r_flit;
    logic              r_we;
    logic              r_done;

    logic [LEN_W-1:0]  w_eff_len;
    logic              w_accept;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_ready;
    logic [FLIT_W-1:0] w_head;
    logic [FLIT_W-1:0] w_body;
    logic [FLIT_W-1:0] w_tail;

    assign w_eff_len   = (body_len > MAX_LEN) ? MAX_LEN : body_len;
    assign w_accept    = (r_state == S_IDLE) && pkt_start;
    assign w_ready     = (r_state == S_BODY) && !fifo_full;
    assign w_beat      = data_valid && w_ready;
    assign w_last_beat = w_beat && (r_cnt == (r_len - LEN_ONE));
    assign w_body      = {REP{sram_data_in}};

    assign data_ready   = w_ready;
    assign busy         = (r_state != S_IDLE);
    assign flit_out     = r_flit;
    assign write_enable = r_we;
    assign pkt_done     = r_done;

    // Head flit: zero type byte, then src, dest at the top; length at the bottom.
    always_comb begin
        w_head = '0;
        w_head[FLIT_W-1 -: 8] = 8'h00;
        w_head[FLIT_W-9 -: ADDR_W] = r_src;
        w_head[FLIT_W-9-ADDR_W -: ADDR_W] = r_dest;
        w_head[LEN_W-1:0] = r_len;
    end

    // Tail flit: all-ones marker word with the packet sequence above it.
    always_comb begin
        w_tail = '0;
        w_tail[DATA_W-1:0] = '1;
        w_tail[DATA_W+7:DATA_W] = r_seq;
    end

    // Next-state logic; HEAD and TAIL only advance when the FIFO has room.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (pkt_start) begin
                    w_state_nxt = S_HEAD;
                end
            end
            S_HEAD: begin
                if (!fifo_full) begin
                    w_state_nxt = (r_len != '0) ? S_BODY : S_TAIL;
                end
            end
            S_BODY: begin
                if (w_last_beat) begin
                    w_state_nxt = S_TAIL;
                end
            end
            S_TAIL: begin
                if (!fifo_full) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Packet context is frozen at acceptance so mid-packet input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src  <= '0;
            r_dest <= '0;
            r_len  <= '0;
        end else if (w_accept) begin
            r_src  <= src_addr;
            r_dest <= dest_addr;
            r_len  <= w_eff_len;
        end
    end

    // Body beat counter, cleared by the final beat of the packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_last_beat) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + LEN_ONE;
        end
    end

    // Sequence number advances on every tail write and wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seq <= '0;
        end else if ((r_state == S_TAIL) && !fifo_full) begin
            r_seq <= r_seq + 8'd1;
        end
    end

    // Flit output register; strobes default low and the flit holds between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flit <= '0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_HEAD: begin
                    if (!fifo_full) begin
                        r_flit <= w_head;
                        r_we   <= 1'b1;
                    end
                end
                S_BODY: begin
                    if (w_beat) begin
                        r_flit <= w_body;
                        r_we   <= 1'b1;
                    end
                end
                S_TAIL: begin
                    if (!fifo_full) begin
                        r_flit <= w_tail;
                        r_we   <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packetizer_param.sv
// tb_packetizer_param: directed checks of packetizer_param with default
// parameters (256-bit flits, 16-bit data, 8-bit addresses, MAX_BODY 8).
module tb_packetizer_param;

    logic         clk;
    logic         reset;
    logic         pkt_start;
    logic [7:0]   src_addr;
    logic [7:0]   dest_addr;
    logic [3:0]   body_len;
    logic [15:0]  sram_data_in;
    logic         data_valid;
    logic         data_ready;
    logic         fifo_full;
    logic [255:0] flit_out;
    logic         write_enable;
    logic         busy;
    logic         pkt_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [255:0] wq[$];
    logic         dq[$];
    int           wc[$];

    packetizer_param dut (
        .clk          (clk),
        .reset        (reset),
        .pkt_start    (pkt_start),
        .src_addr     (src_addr),
        .dest_addr    (dest_addr),
        .body_len     (body_len),
        .sram_data_in (sram_data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .fifo_full    (fifo_full),
        .flit_out     (flit_out),
        .write_enable (write_enable),
        .busy         (busy),
        .pkt_done     (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            wq.push_back(flit_out);
            dq.push_back(pkt_done);
            wc.push_back(cyc);
        end
    end

    function automatic logic [255:0] mk_head(input logic [7:0] s,
                                             input logic [7:0] d,
                                             input logic [3:0] l);
        logic [255:0] h;
        h = 256'(l);
        h = h | (256'({8'h00, s, d}) << 232);
        return h;
    endfunction

    function automatic logic [255:0] mk_body(input logic [15:0] w);
        return {16{w}};
    endfunction

    function automatic logic [255:0] mk_tail(input logic [7:0] q);
        return 256'h0000FFFF | (256'(q) << 16);
    endfunction

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #5;
    endtask

    task automatic clr();
        wq.delete();
        dq.delete();
        wc.delete();
    endtask

    task automatic start(input logic [7:0] s, input logic [7:0] d,
                         input logic [3:0] l);
        src_addr  = s;
        dest_addr = d;
        body_len  = l;
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        src_addr  = ~s;
        dest_addr = ~d;
        body_len  = ~l;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (pkt_done === 1'b1) break;
        end
        check(tag, pkt_done, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        pkt_start = 1'b0;
        src_addr = '0;
        dest_addr = '0;
        body_len = '0;
        sram_data_in = '0;
        data_valid = 1'b0;
        fifo_full = 1'b0;
        step();
        step();
        check("rst_flit", flit_out, '0);
        check("rst_we", write_enable, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", pkt_done, 1'b0);
        check("rst_ready", data_ready, 1'b0);
        reset = 1'b0;
        step();

        // 1: single-beat packet
        clr();
        data_valid = 1'b1;
        sram_data_in = 16'hABCD;
        start(8'h12, 8'h34, 4'd1);
        check("t1_busy", busy, 1'b1);
        wait_done("t1_done", 10);
        settle();
        check("t1_count", wq.size(), 3);
        if (wq.size() == 3) begin
            check("t1_head", wq[0], (256'h001234 << 232) | 256'h1);
            check("t1_body", wq[1], mk_body(16'hABCD));
            check("t1_tail", wq[2], 256'h0000FFFF);
            check("t1_done_hd", dq[0], 1'b0);
            check("t1_done_tl", dq[2], 1'b1);
            check("t1_consec", wc[2] - wc[0], 2);
        end

        // 2: stalled data_valid between beats
        clr();
        data_valid = 1'b0;
        start(8'hA1, 8'hB2, 4'd3);
        step();
        check("t2_head_we", write_enable, 1'b1);
        check("t2_ready", data_ready, 1'b1);
        data_valid = 1'b1;
        sram_data_in = 16'h1111;
        step();
        check("t2_b1_we", write_enable, 1'b1);
        data_valid = 1'b0;
        step();
        check("t2_stall_we", write_enable, 1'b0);
        check("t2_stall_rdy", data_ready, 1'b1);
        step();
        check("t2_stall2_we", write_enable, 1'b0);
        data_valid = 1'b1;
        sram_data_in = 16'h2222;
        step();
        data_valid = 1'b0;
        step();
        step();
        check("t2_stall3_we", write_enable, 1'b0);
        data_valid = 1'b1;
        sram_data_in = 16'h3333;
        step();
        data_valid = 1'b0;
        wait_done("t2_done", 5);
        settle();
        check("t2_count", wq.size(), 5);
        if (wq.size() == 5) begin
            check("t2_head", wq[0], mk_head(8'hA1, 8'hB2, 4'd3));
            check("t2_b1", wq[1], mk_body(16'h1111));
            check("t2_b2", wq[2], mk_body(16'h2222));
            check("t2_b3", wq[3], mk_body(16'h3333));
            check("t2_tail", wq[4], mk_tail(8'd1));
        end

        // 3: fifo_full during HEAD and BODY
        clr();
        fifo_full = 1'b1;
        data_valid = 1'b1;
        sram_data_in = 16'h5A5A;
        start(8'h01, 8'h02, 4'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_hfull_we", write_enable, 1'b0);
        end
        check("t3_hfull_busy", busy, 1'b1);
        fifo_full = 1'b0;
        step();
        check("t3_head_we", write_enable, 1'b1);
        fifo_full = 1'b1;
        #1;
        check("t3_bfull_rdy", data_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t3_bfull_we", write_enable, 1'b0);
            check("t3_bfull_rdy2", data_ready, 1'b0);
        end
        fifo_full = 1'b0;
        wait_done("t3_done", 10);
        settle();
        check("t3_count", wq.size(), 4);
        if (wq.size() == 4) begin
            check("t3_head", wq[0], mk_head(8'h01, 8'h02, 4'd2));
            check("t3_b1", wq[1], mk_body(16'h5A5A));
            check("t3_b2", wq[2], mk_body(16'h5A5A));
            check("t3_tail", wq[3], mk_tail(8'd2));
        end

        // 4a: zero-length body
        clr();
        data_valid = 1'b0;
        start(8'h77, 8'h88, 4'd0);
        wait_done("t4a_done", 10);
        settle();
        check("t4a_count", wq.size(), 2);
        if (wq.size() == 2) begin
            check("t4a_head", wq[0], mk_head(8'h77, 8'h88, 4'd0));
            check("t4a_tail", wq[1], mk_tail(8'd3));
        end

        // 4b: clamped length
        clr();
        data_valid = 1'b1;
        sram_data_in = 16'h0F0F;
        start(8'h9A, 8'hBC, 4'd15);
        wait_done("t4b_done", 20);
        settle();
        check("t4b_count", wq.size(), 10);
        if (wq.size() == 10) begin
            check("t4b_head", wq[0], mk_head(8'h9A, 8'hBC, 4'd8));
            check("t4b_b1", wq[1], mk_body(16'h0F0F));
            check("t4b_b8", wq[8], mk_body(16'h0F0F));
            check("t4b_tail", wq[9], mk_tail(8'd4));
        end

        // 5: sequence wrap over 257 back-to-back packets
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr();
        data_valid = 1'b0;
        for (int i = 0; i < 257; i++) begin
            start(8'h10, 8'h20, 4'd0);
            wait_done("t5_done", 5);
            check("t5_seq", flit_out, mk_tail(8'(i)));
        end
        settle();
        check("t5_count", wq.size(), 514);
        if (wq.size() == 514) begin
            check("t5_spacing", wc[513] - wc[1], 768);
        end

        // 5b: pkt_start while busy is ignored
        clr();
        data_valid = 1'b1;
        sram_data_in = 16'hC3C3;
        start(8'h44, 8'h55, 4'd2);
        step();
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        wait_done("t5b_done", 10);
        settle();
        step();
        step();
        step();
        check("t5b_count", wq.size(), 4);
        check("t5b_idle", busy, 1'b0);
        if (wq.size() == 4) begin
            check("t5b_tail", wq[3], mk_tail(8'd1));
        end

        // 6: reset mid-body
        clr();
        data_valid = 1'b1;
        sram_data_in = 16'hDEAD;
        start(8'h66, 8'h99, 4'd4);
        step();
        step();
        check("t6_b1_we", write_enable, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_flit", flit_out, '0);
        check("t6_we", write_enable, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", pkt_done, 1'b0);
        step();
        reset = 1'b0;
        clr();
        sram_data_in = 16'h7777;
        start(8'h03, 8'h04, 4'd1);
        wait_done("t6_pdone", 10);
        settle();
        check("t6_count", wq.size(), 3);
        if (wq.size() == 3) begin
            check("t6_head", wq[0], mk_head(8'h03, 8'h04, 4'd1));
            check("t6_body", wq[1], mk_body(16'h7777));
            check("t6_tail", wq[2], mk_tail(8'd0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/packetizer_param.md
Name: packetizer_param

Overview:
Parametrised packetizer that turns one SRAM read stream into a head/body/tail flit packet for the router input FIFO. Generalises the fixed three-flit packetizer in four ways:
- configurable flit, data and address widths
- variable body length per packet
- FIFO backpressure (fifo_full) and a valid/ready data handshake
- 8-bit packet sequence number carried in the tail flit

Sits between the SRAM read port and the router input FIFO.

Parameters:
FLIT_W, 256, flit width in bits; must be a multiple of DATA_W and at least 2*ADDR_W+8+LEN_W.
DATA_W, 16, SRAM data word width.
ADDR_W, 8, source/destination address width.
LEN_W, 4, width of body_len.
MAX_BODY, 8, maximum body flits per packet (1..2^LEN_W-1).

Ports:
clk  input  1  main clock, rising edge
reset  input  1  asynchronous, active-high reset
pkt_start  input  1  request a new packet; sampled only in IDLE
src_addr  input  ADDR_W  source address, latched on accepted pkt_start
dest_addr  input  ADDR_W  destination address, latched on accepted pkt_start
body_len  input  LEN_W  number of body flits, latched on accepted pkt_start
sram_data_in  input  DATA_W  body data word
data_valid  input  1  sram_data_in valid
data_ready  output  1  combinational: state==BODY && !fifo_full
fifo_full  input  1  downstream FIFO full; no flit is written while high
flit_out  output  FLIT_W  flit to FIFO, registered
write_enable  output  1  FIFO write strobe, registered, one cycle per flit
busy  output  1  state != IDLE
pkt_done  output  1  one-cycle pulse, registered with the tail flit write

Behaviour:
- Reset (async): state=IDLE, flit_out=0, write_enable=0, pkt_done=0, body counter=0, seq=0, latched src/dest/len=0.
- FSM: IDLE, HEAD, BODY, TAIL. write_enable and pkt_done default to 0 every cycle; flit_out holds its last value when nothing is written.
- IDLE:
  - pkt_start=1 latches src_addr, dest_addr and eff_len, then goes to HEAD.
  - eff_len = min(body_len, MAX_BODY).
  - pkt_start is ignored while busy.
- HEAD:
  - If !fifo_full: write the head flit (write_enable<=1).
  - Head flit: bits[FLIT_W-1 -: 8]=8'h00, next ADDR_W bits = src, next ADDR_W bits = dest, bits[LEN_W-1:0]=eff_len, all other bits 0.
  - Next state is BODY if eff_len!=0, otherwise TAIL.
  - If fifo_full: stay in HEAD, no write.
- BODY:
  - A beat is accepted when data_valid && data_ready.
  - On a beat: flit_out <= sram_data_in replicated FLIT_W/DATA_W times, write_enable<=1, counter++.
  - The beat that brings counter to eff_len moves to TAIL and clears the counter.
  - No beat means no write and no state change.
- TAIL:
  - If !fifo_full: write the tail flit, write_enable<=1, pkt_done<=1, seq<=seq+1 (wraps 255->0), next state IDLE.
  - Tail flit: bits[DATA_W-1:0] all ones, bits[DATA_W+7:DATA_W]=seq (value before increment), all other bits 0.
  - If fifo_full: stay in TAIL.
- Latency with fifo_full=0 and data_valid held 1:
  - pkt_start sampled at edge N.
  - Head written at edge N+1.
  - Body k written at edge N+1+k.
  - Tail written at edge N+2+eff_len.
  - Next pkt_start is accepted at edge N+3+eff_len (one IDLE cycle between packets).
- fifo_full is sampled at the same edge as the write decision. A write never occurs at an edge where fifo_full=1.
- body_len > MAX_BODY is clamped; body_len=0 produces a head+tail packet.
- Changes to src/dest/len inputs mid-packet have no effect on the packet in flight.
- Reset mid-packet aborts immediately. The partially written packet is not completed; seq returns to 0.

Test Plan:
1. Reset, then pkt_start with src=0x12, dest=0x34, len=1, data 0xABCD, FLIT_W=256 -> 3 consecutive writes:
   - head = 0x00_12_34 in the top 24 bits, 0x1 in the low bits
   - body = 0xABCD repeated 16 times
   - tail = 0x...00_FFFF with seq 0x00 in bits[23:16]
   - pkt_done high with the tail write.
2. len=3 with data_valid low for 2 cycles between beats -> exactly 5 writes; no write and data_ready high while stalled; body flits in order.
3. fifo_full asserted for 4 cycles during HEAD, then for 2 cycles in BODY -> write_enable stays 0 throughout; data_ready=0 during the BODY stall; the packet completes unchanged afterwards.
4. body_len=0 -> head then tail only. body_len=15 with MAX_BODY=8 -> head shows len 8, 8 body flits, tail.
5. 257 back-to-back packets -> tail seq counts 0..255 then 0. pkt_start pulsed while busy is ignored (write count unchanged).
6. Assert reset in BODY after 1 of 4 beats -> outputs zero asynchronously, busy=0; the next packet starts with a clean head and seq=0.
